// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared types/constants for the 5-stage core controller    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_pkg;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        FILL   = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } pipe_state_t;

    localparam int PIPE_FILL_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_counter : wrap-around counter, sync active-low clear, inc enable |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_ctrl : stall/flush sequencing, stage valids, halt FSM, perf  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             pc_write_id,
    input  logic             hazard_mux,
    input  logic             flush,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_bubble,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FILL_W = $clog2(PIPE_FILL_CYCLES + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PIPE_FILL_CYCLES - 1);

    pipe_state_t       state;
    pipe_state_t       state_nxt;
    logic [FILL_W-1:0] fill_cnt;
    logic              active;
    logic              stall;
    logic              kill;
    logic              stopping;
    logic              pipe_empty;

    assign active     = (state == FILL) || (state == RUN) || (state == DRAIN);
    assign kill       = active && flush;
    assign stall      = active && (!pc_write_id || hazard_mux) && !flush;
    // Fetch stops in the very cycle halt is requested so the drain takes 4 cycles.
    assign stopping   = (state == DRAIN) || (((state == FILL) || (state == RUN)) && halt_req);
    assign pipe_empty = !(v_id || v_ex || v_mem || v_wb);

    always_comb begin
        state_nxt    = state;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b0;
        if (active) begin
            pc_en        = !stall && !stopping;
            if_id_en     = !stall;
            id_ex_bubble = stall;
        end
        case (state)
            RESET:   state_nxt = FILL;
            FILL: begin
                if (halt_req)                   state_nxt = DRAIN;
                else if (fill_cnt == FILL_LAST) state_nxt = RUN;
            end
            RUN:     if (halt_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!halt_req)       state_nxt = RUN;
                else if (pipe_empty) state_nxt = HALTED;
            end
            HALTED:  if (!halt_req) state_nxt = FILL;
            default: state_nxt = RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state    <= RESET;
            fill_cnt <= '0;
            halted   <= 1'b0;
            v_id     <= 1'b0;
            v_ex     <= 1'b0;
            v_mem    <= 1'b0;
            v_wb     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= (state == FILL) ? fill_cnt + 1'b1 : '0;
            halted   <= (state_nxt == HALTED);
            if (active) begin
                // A stalled ID instruction is kept even while draining.
                if (kill)          v_id <= 1'b0;
                else if (stall)    v_id <= v_id;
                else if (stopping) v_id <= 1'b0;
                else               v_id <= 1'b1;
                v_ex  <= (kill || stall) ? 1'b0 : v_id;
                v_mem <= v_ex;
                v_wb  <= v_mem;
            end else begin
                v_id  <= 1'b0;
                v_ex  <= 1'b0;
                v_mem <= 1'b0;
                v_wb  <= 1'b0;
            end
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk(CLK), .clr_n(RST_n), .inc(state != RESET), .count(cycle_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk(CLK), .clr_n(RST_n), .inc(v_wb), .count(retire_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(CLK), .clr_n(RST_n), .inc(stall), .count(stall_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(CLK), .clr_n(RST_n), .inc(flush && (state != RESET)), .count(flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_ctrl : directed bench for pipeline_ctrl (CNT_W=32 and 4)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write_id;
    logic        hazard_mux;
    logic        flush;
    logic        halt_req;
    logic        pc_en, if_id_en, id_ex_bubble;
    logic        v_id, v_ex, v_mem, v_wb, halted;
    logic [31:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;
    logic        pc_en4, if_id_en4, id_ex_bubble4;
    logic        v_id4, v_ex4, v_mem4, v_wb4, halted4;
    logic [3:0]  cycle_cnt4, retire_cnt4, stall_cnt4, flush_cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK(clk), .RST_n(rst_n), .pc_write_id(pc_write_id), .hazard_mux(hazard_mux),
        .flush(flush), .halt_req(halt_req), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_bubble(id_ex_bubble), .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem),
        .v_wb(v_wb), .halted(halted), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST_n(rst_n), .pc_write_id(pc_write_id), .hazard_mux(hazard_mux),
        .flush(flush), .halt_req(halt_req), .pc_en(pc_en4), .if_id_en(if_id_en4),
        .id_ex_bubble(id_ex_bubble4), .v_id(v_id4), .v_ex(v_ex4), .v_mem(v_mem4),
        .v_wb(v_wb4), .halted(halted4), .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_valids(input string tag, input logic [3:0] exp);
        check(tag, 32'({v_id, v_ex, v_mem, v_wb}), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; pc_write_id = 1'b1; hazard_mux = 1'b0; flush = 1'b0; halt_req = 1'b0;
        step(); step();
        check_valids("reset_valids", 4'b0000);
        check("reset_cycle", cycle_cnt, 0);
        check("reset_halted", 32'(halted), 0);
        check("reset_pc_en", 32'(pc_en), 0);
        check("reset_if_id_en", 32'(if_id_en), 0);

        // Release: edge 1 enters FILL, valid chain fills over edges 2..5
        rst_n = 1'b1; settle();
        check("release_pc_en", 32'(pc_en), 0);
        step();
        check("fill_pc_en", 32'(pc_en), 1);
        check("fill_if_id_en", 32'(if_id_en), 1);
        check_valids("fill_e1", 4'b0000);
        step();
        check_valids("fill_e2", 4'b1000);
        step(); step();
        check_valids("fill_e4", 4'b1110);
        step();
        check_valids("fill_e5", 4'b1111);
        check("retire_e5", retire_cnt, 0);
        check("cycle_e5", cycle_cnt, 4);
        step();
        check("retire_e6", retire_cnt, 1);
        check("cycle_e6", cycle_cnt, 5);
        for (int i = 0; i < 15; i++) step();
        check("cycle_e21", cycle_cnt, 20);
        check("cycle4_wrap", 32'(cycle_cnt4), 4);
        check("retire4_wrap", 32'(retire_cnt4), 0);
        check("retire_e21", retire_cnt, 16);

        // Two-cycle load-use stall
        pc_write_id = 1'b0; hazard_mux = 1'b1; settle();
        check("stall1_pc_en", 32'(pc_en), 0);
        check("stall1_if_id_en", 32'(if_id_en), 0);
        check("stall1_bubble", 32'(id_ex_bubble), 1);
        step();
        check_valids("stall_e22", 4'b1011);
        check("stall2_pc_en", 32'(pc_en), 0);
        check("stall2_if_id_en", 32'(if_id_en), 0);
        step();
        check_valids("stall_e23", 4'b1001);
        check("stall_cnt2", stall_cnt, 2);
        pc_write_id = 1'b1; hazard_mux = 1'b0; settle();
        check("unstall_pc_en", 32'(pc_en), 1);
        step();
        check_valids("stall_e24", 4'b1100);
        check("stall_cnt_hold", stall_cnt, 2);

        // Flush coinciding with a stall request
        flush = 1'b1; hazard_mux = 1'b1; settle();
        check("flush_pc_en", 32'(pc_en), 1);
        check("flush_bubble", 32'(id_ex_bubble), 0);
        step();
        check_valids("flush_e25", 4'b0010);
        check("flush_cnt1", flush_cnt, 1);
        check("flush_stall_cnt", stall_cnt, 2);
        flush = 1'b0; hazard_mux = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_valids("refill_e29", 4'b1111);

        // Halt and drain
        halt_req = 1'b1; settle();
        check("halt_pc_en", 32'(pc_en), 0);
        step();
        check_valids("drain_e30", 4'b0111);
        check("drain_pc_en", 32'(pc_en), 0);
        step(); step(); step();
        check_valids("drain_e33", 4'b0000);
        check("drain_halted", 32'(halted), 0);
        flush = 1'b1; settle();
        step();
        check("halted", 32'(halted), 1);
        check("exit_flush_cnt", flush_cnt, 2);
        flush = 1'b0; halt_req = 1'b0; settle();
        check("halted_pc_en", 32'(pc_en), 0);
        step();
        check("resume_pc_en", 32'(pc_en), 1);
        check("resume_halted", 32'(halted), 0);
        step();
        check_valids("resume_e36", 4'b1000);
        step();

        // Reset mid-run
        rst_n = 1'b0;
        step();
        check_valids("midrst_valids", 4'b0000);
        check("midrst_cycle", cycle_cnt, 0);
        check("midrst_retire", retire_cnt, 0);
        check("midrst_stall", stall_cnt, 0);
        check("midrst_flush", flush_cnt, 0);
        check("midrst_pc_en", 32'(pc_en), 0);
        rst_n = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It consumes the stall and flush requests raised by the hazard detection unit and turns them into per-stage register enables, bubble insertion and per-stage valid bits. It also runs a start-up/halt state machine and keeps wrap-around performance counters. It sits beside the hazard detection unit in the core top level and drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables.

## Interface
- CNT_W, 32, width of every performance counter
- CLK  in  1  core clock, all state on rising edge
- RST_n  in  1  synchronous active-low reset
- pc_write_id  in  1  0 = load-use stall requested (freeze PC and IF/ID)
- hazard_mux  in  1  1 = insert bubble into ID/EX
- flush  in  1  kill the instructions currently in IF/ID and ID/EX
- halt_req  in  1  level; request to drain the pipeline and stop fetch
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register load enable
- id_ex_bubble  out  1  ID/EX loads a NOP with valid=0
- v_id, v_ex, v_mem, v_wb  out  1 each  per-stage valid bits
- halted  out  1  pipeline empty and fetch stopped
- cycle_cnt, retire_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- States: RESET, FILL, RUN, DRAIN, HALTED.
- RESET: entered while RST_n=0. All valids are 0, all counters are 0, halted=0, pc_en=0 and if_id_en=0. The first cycle with RST_n=1 moves to FILL.
- FILL: pc_en=1 and if_id_en=1. Each cycle v_id is set to 1 and the valid chain shifts (v_ex<=v_id, v_mem<=v_ex, v_wb<=v_mem). After 4 FILL cycles the state moves to RUN. Stall and flush requests are honoured in FILL exactly as in RUN.
- RUN, no request: pc_en=1, if_id_en=1, v_id<=1, and the chain shifts.
- Stall (pc_write_id=0 or hazard_mux=1):
  - pc_en=0 and if_id_en=0, v_id held.
  - id_ex_bubble=1, v_ex<=0.
  - v_mem<=v_ex and v_wb<=v_mem.
- Flush (flush=1): v_id<=0 and v_ex<=0; pc_en=1 for the redirect; v_mem<=v_ex and v_wb<=v_mem. Flush has priority over a stall in the same cycle: no freeze, and the bubble is implied by v_ex<=0.
- halt_req=1 in RUN or FILL moves to DRAIN. In DRAIN: pc_en=0, v_id<=0, and the chain continues to shift and honour stall/flush. When v_id|v_ex|v_mem|v_wb==0, the state moves to HALTED.
- HALTED: halted=1, pc_en=0, if_id_en=0, all valids 0. Dropping halt_req moves to FILL. halt_req dropped while in DRAIN returns to RUN.
- Counters, each wrapping modulo 2^CNT_W:
  - cycle_cnt: +1 every cycle outside RESET.
  - retire_cnt: +1 when v_wb=1.
  - stall_cnt: +1 per stall cycle not overridden by a flush.
  - flush_cnt: +1 per cycle with flush=1.

## Timing
- pc_en, if_id_en and id_ex_bubble are combinational from the current state and inputs. A stall must take effect in the same cycle it is requested.
- Valid bits, counters, state and halted are registered, with 1-cycle latency from the inputs.
- Reset values: state RESET, all outputs 0.
- Reset mid-operation: in-flight valids are discarded and the counters clear on the same edge.
- A stall held for N cycles yields exactly N bubbles in v_ex and N stall_cnt increments.
- Counter wrap: a counter at all-ones returns to 0 on its next increment, with no sticky flag.
- A flush arriving on the DRAIN-to-HALTED exit cycle is still counted in flush_cnt.

## Structure
- Shared core package `riscv_pkg` holds:
  - the state enum `pipe_state_t` (RESET, FILL, RUN, DRAIN, HALTED);
  - the localparam `PIPE_FILL_CYCLES = 4`.
- One sub-module, `perf_counter`: a parameterised CNT_W wrap-around counter with synchronous active-low clear and an increment enable. It is instantiated four times.

## Test plan
- Reset release, no requests → FILL for 4 cycles; v_wb first goes 1 on cycle 4; RUN on cycle 5; retire_cnt=1 one cycle after v_wb rises.
- In RUN, pc_write_id=0 and hazard_mux=1 for 2 cycles → pc_en=0 and if_id_en=0 in both cycles; v_ex=0 for 2 cycles; stall_cnt=2; v_id stays 1.
- flush=1 and hazard_mux=1 in the same cycle → pc_en=1; v_id=0 and v_ex=0 next cycle; flush_cnt=1; stall_cnt unchanged.
- halt_req asserted in RUN → pc_en=0; valids empty after 4 cycles; halted=1; dropping halt_req → FILL, pc_en=1.
- Preload with CNT_W=4: 16 RUN cycles after FILL → cycle_cnt wraps to 4 (20 mod 16); reset asserted mid-RUN → all counters and valids 0 on the next edge.
